// File: rtl/pulse_stretch_tx.sv
// pulse_stretch_tx: turns single-cycle event strobes into stretched level pulses with
// guaranteed high/low times, queueing events that arrive mid-pulse. Optional macro OVF_CLR_EN adds ovf_clr.
module pulse_stretch_tx #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              evt,
`ifdef OVF_CLR_EN
  input  logic              ovf_clr,
`endif
  output logic              sig_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAX_PH = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CNT_W  = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              high_done, low_done, restart;
  logic              inc, dec, ovf_set, ovf_keep;
  logic [PEND_W-1:0] pend_next;

  assign high_done = (state == HIGH) && (cnt == HIGH_LAST);
  assign low_done  = (state == LOW)  && (cnt == LOW_LAST);
  // A same-cycle evt on the final LOW cycle counts as something to send, even with an empty queue.
  assign restart   = low_done && ((pending != '0) || evt);
  assign inc       = evt && (state != IDLE);
  assign dec       = restart;

`ifdef OVF_CLR_EN
  assign ovf_keep = overflow && !ovf_clr;
`else
  assign ovf_keep = overflow;
`endif

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    pend_next = pending;
    ovf_set   = 1'b0;
    if (inc && !dec) begin
      if (&pending) ovf_set = 1'b1;
      else          pend_next = pending + PEND_W'(1);
    end else if (dec && !inc) begin
      pend_next = pending - PEND_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sig_out  <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pend_next;
      overflow <= ovf_set || ovf_keep;
      unique case (state)
        IDLE: begin
          if (evt) begin
            state   <= HIGH;
            cnt     <= '0;
            sig_out <= 1'b1;
            busy    <= 1'b1;
          end
        end
        HIGH: begin
          if (high_done) begin
            state   <= LOW;
            cnt     <= '0;
            sig_out <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LOW: begin
          if (low_done) begin
            cnt <= '0;
            if (restart) begin
              state   <= HIGH;
              sig_out <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          sig_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
